// File: rtl/rv32m_mul_sequencer.sv
// rv32m_mul_sequencer: control stage in front of the unsigned 32x32 shift-add
// multiplier. Converts RV32M signed operands to magnitudes, launches the
// multiplier, applies sign correction to the 64-bit product and returns the
// selected half over a valid/ready handshake. A watchdog turns a multiplier
// that never completes into an error response.
// Optional feature: define MUL_ZERO_BYPASS_EN to answer requests with a zero
// operand directly, without launching the multiplier.
module rv32m_mul_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic [63:0] mul_result,
  input  logic        mul_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, GUARD, WAIT, FIX, OUT} state_t;

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd_cnt;
  logic            neg;
  logic            hi_sel;
  logic [63:0]     prod;
  logic [63:0]     prod_fixed;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [31:0]     mag_a;
  logic [31:0]     mag_b;
  logic            accept;
  logic            zero_op;
  logic            timeout;

  // MULH treats both operands as signed, MULHSU only A; MUL/MULHU neither.
  assign a_signed = (req_op == 2'b01) || (req_op == 2'b10);
  assign b_signed = (req_op == 2'b01);
  assign a_neg    = a_signed && req_rs1[31];
  assign b_neg    = b_signed && req_rs2[31];
  // 0x80000000 negates to itself, which is the correct unsigned 2^31.
  assign mag_a    = a_neg ? (~req_rs1 + 32'd1) : req_rs1;
  assign mag_b    = b_neg ? (~req_rs2 + 32'd1) : req_rs2;

  assign accept     = (state == IDLE) && req_valid;
  assign timeout    = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign prod_fixed = neg ? (~prod + 64'd1) : prod;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (req_rs1 == 32'd0) || (req_rs2 == 32'd0);
`else
  assign zero_op = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; in WAIT a done flag wins over a simultaneous expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = zero_op ? OUT : LAUNCH;
      LAUNCH:  state_next = GUARD;
      GUARD:   state_next = WAIT;
      WAIT:    if (mul_done) state_next = FIX;
               else if (timeout) state_next = OUT;
      FIX:     state_next = OUT;
      OUT:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register.
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    rsp_valid = (state == OUT);
  end

  // Datapath: operand capture, launch pulse, watchdog, product and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
      neg       <= 1'b0;
      hi_sel    <= 1'b0;
      wd_cnt    <= '0;
      prod      <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // The pulse is the registered LAUNCH decode, so it rises one edge after
      // the operands and the multiplier sees them stable for a full cycle.
      // It is high while the FSM sits in GUARD, where a stale done is ignored.
      mul_start <= (state == LAUNCH);
      if (accept) begin
        mul_a  <= mag_a;
        mul_b  <= mag_b;
        neg    <= a_neg ^ b_neg;
        hi_sel <= (req_op != 2'b00);
        if (zero_op) begin
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
      end
      if (state == GUARD) wd_cnt <= '0;
      if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (mul_done) begin
          prod <= mul_result;
        end else if (timeout) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (state == FIX) begin
        rsp_data <= hi_sel ? prod_fixed[63:32] : prod_fixed[31:0];
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_mul_sequencer.sv
// Directed testbench for rv32m_mul_sequencer. Contains a 33-cycle behavioural
// multiplier (done is a level cleared by the next start) that can be told to
// never complete, for exercising the watchdog.
module tb_rv32m_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic [63:0] mul_result;
  logic        mul_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int tests_run = 0;
  int fails = 0;
  int start_cnt = 0;
  logic never_done = 1'b0;

  rv32m_mul_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_result(mul_result), .mul_done(mul_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done rises 33 edges after the edge sampling start.
  logic [5:0] m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0; mul_done <= 1'b0; mul_result <= '0;
    end else if (mul_start) begin
      m_cnt <= 6'd33; mul_done <= 1'b0;
      mul_result <= {32'd0, mul_a} * {32'd0, mul_b};
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1 && !never_done) mul_done <= 1'b1;
    end
  end

  always @(posedge clk) if (mul_start) start_cnt = start_cnt + 1;

  // Issue one request with rsp_ready high. lat counts edges from the accept
  // edge to the edge after which rsp_valid is seen (0 = valid in the cycle
  // right after acceptance).
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output logic err, output int lat,
                        output int starts, output logic [31:0] ma, output logic [31:0] mb);
    int s0;
    @(negedge clk);
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; rsp_ready = 1'b1;
    s0 = start_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    data = rsp_data; err = rsp_err; ma = mul_a; mb = mul_b;
    starts = start_cnt - s0;
    $display("[TB] op=%0d a=%h b=%h -> data=%h err=%0b lat=%0d starts=%0d", op, a, b, data, err, lat, starts);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests_run++; if (rsp_data !== 32'd0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    tests_run++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    tests_run++; if (mul_start !== 1'b0) begin fails++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
    tests_run++; if ({mul_a, mul_b} !== 64'd0) begin fails++; $display("FAIL reset_operands got %h/%h want 0/0", mul_a, mul_b); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_mul_basic;
    logic [31:0] d, ma, mb; logic e; int lat, st;
    do_req(2'b00, 32'd7, 32'd6, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'h0000002A) begin fails++; $display("FAIL mul7x6_data got %h want 0000002a", d); end
    tests_run++; if (e !== 1'b0) begin fails++; $display("FAIL mul7x6_err got %b want 0", e); end
    tests_run++; if (st !== 1) begin fails++; $display("FAIL mul7x6_starts got %0d want 1", st); end
    tests_run++; if (ma !== 32'd7 || mb !== 32'd6) begin fails++; $display("FAIL mul7x6_operands got %h/%h want 7/6", ma, mb); end
    tests_run++; if (lat !== 37) begin fails++; $display("FAIL mul7x6_latency got %0d want 37", lat); end
  endtask

  task automatic test_signed;
    logic [31:0] d, ma, mb; logic e; int lat, st;
    do_req(2'b01, 32'h80000000, 32'h80000000, d, e, lat, st, ma, mb);
    tests_run++; if (ma !== 32'h80000000 || mb !== 32'h80000000) begin fails++; $display("FAIL mulh_min_operands got %h/%h want 80000000/80000000", ma, mb); end
    tests_run++; if (d !== 32'h40000000) begin fails++; $display("FAIL mulh_min_data got %h want 40000000", d); end
    do_req(2'b11, 32'h80000000, 32'h80000000, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'h40000000) begin fails++; $display("FAIL mulhu_min_data got %h want 40000000", d); end
    do_req(2'b00, 32'h80000000, 32'h80000000, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'h00000000) begin fails++; $display("FAIL mul_min_data got %h want 00000000", d); end
    do_req(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, lat, st, ma, mb);
    tests_run++; if (ma !== 32'd1 || mb !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu_operands got %h/%h want 00000001/ffffffff", ma, mb); end
    tests_run++; if (d !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu_data got %h want ffffffff", d); end
    do_req(2'b00, 32'hFFFFFFFD, 32'd5, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'hFFFFFFF1) begin fails++; $display("FAIL mul_m3x5_data got %h want fffffff1", d); end
    do_req(2'b01, 32'hFFFFFFFD, 32'd5, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulh_m3x5_data got %h want ffffffff", d); end
    // 0x12345678 * -16 = 0xFFFFFFFE_DCBA9880
    do_req(2'b01, 32'h12345678, 32'hFFFFFFF0, d, e, lat, st, ma, mb);
    tests_run++; if (mb !== 32'h00000010) begin fails++; $display("FAIL mulh_neg_b_operand got %h want 00000010", mb); end
    tests_run++; if (d !== 32'hFFFFFFFE) begin fails++; $display("FAIL mulh_neg_b_data got %h want fffffffe", d); end
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_rs1 = 32'h00010000; req_rs2 = 32'h00010000; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // A second request stays pending for the whole operation.
    req_op = 2'b00; req_rs1 = 32'd9; req_rs2 = 32'd9;
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    tests_run++; if (rsp_data !== 32'd1) begin fails++; $display("FAIL bp_data got %h want 00000001", rsp_data); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || req_ready !== 1'b0 || mul_a !== 32'h00010000) begin
        fails++;
        $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b mul_a=%h want 1/00000001/0/00010000", i, rsp_valid, rsp_data, req_ready, mul_a);
      end
    end
    $display("[TB] backpressure held 10 cycles, data=%h", rsp_data);
    rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got busy=%b ready=%b valid=%b want 0/1/0", busy, req_ready, rsp_valid); end
    tests_run++; if (mul_a !== 32'h00010000) begin fails++; $display("FAIL bp_no_early_accept got mul_a=%h want 00010000", mul_a); end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (mul_a !== 32'd9 || busy !== 1'b1) begin fails++; $display("FAIL bp_next_accept got mul_a=%h busy=%b want 00000009/1", mul_a, busy); end
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    tests_run++; if (rsp_data !== 32'd81) begin fails++; $display("FAIL bp_next_data got %h want 00000051", rsp_data); end
    $display("[TB] follow-up MUL 9x9 -> data=%h", rsp_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_zero;
    logic [31:0] d, ma, mb; logic e; int lat, st;
    do_req(2'b00, 32'd0, 32'h1234, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'd0 || e !== 1'b0) begin fails++; $display("FAIL zero_data got %h err=%b want 0 err=0", d, e); end
`ifdef MUL_ZERO_BYPASS_EN
    tests_run++; if (lat !== 0) begin fails++; $display("FAIL zero_latency got %0d want 0", lat); end
    tests_run++; if (st !== 0) begin fails++; $display("FAIL zero_starts got %0d want 0", st); end
`else
    tests_run++; if (lat !== 37) begin fails++; $display("FAIL zero_latency got %0d want 37", lat); end
    tests_run++; if (st !== 1) begin fails++; $display("FAIL zero_starts got %0d want 1", st); end
`endif
  endtask

  task automatic test_timeout;
    logic [31:0] d, ma, mb; logic e; int lat, st;
    never_done = 1'b1;
    // Accept edge, LAUNCH, GUARD, then 64 WAIT cycles.
    do_req(2'b00, 32'd3, 32'd4, d, e, lat, st, ma, mb);
    tests_run++; if (e !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL timeout_resp got err=%b data=%h want 1/0", e, d); end
    tests_run++; if (lat !== 66) begin fails++; $display("FAIL timeout_latency got %0d want 66", lat); end
    // Reset in the middle of WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'hFFFFFFFB; req_rs2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || mul_start !== 1'b0 ||
        mul_a !== 32'd0 || mul_b !== 32'd0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL midwait_reset got busy=%b valid=%b ready=%b start=%b a=%h b=%h data=%h err=%b want all 0",
               busy, rsp_valid, req_ready, mul_start, mul_a, mul_b, rsp_data, rsp_err);
    end
    $display("[TB] reset mid-WAIT: busy=%b valid=%b", busy, rsp_valid);
    @(negedge clk);
    rst = 1'b0;
    never_done = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset got ready=%b busy=%b want 1/0", req_ready, busy); end
    do_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, d, e, lat, st, ma, mb);
    tests_run++; if (d !== 32'hFFFFFFFE || e !== 1'b0) begin fails++; $display("FAIL recover_mulhu got %h err=%b want fffffffe err=0", d, e); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_signed();
    test_backpressure();
    test_zero();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1, "simulation time limit");
  end

endmodule
